// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side drain engine.
// Contents: occupancy encoding of the output buffer and its depth.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_rd_prefetch_if.sv
// Bundle for the drain engine: FIFO read port plus downstream valid/ready stream.
// Ports (master = drain engine view):
//   rempty  in   FIFO empty flag (read domain)
//   rdata   in   FIFO read data, valid the cycle after rinc
//   rinc    out  pop request to the FIFO
//   m_valid out  output word available
//   m_ready in   downstream accepts the word
//   m_data  out  output word
interface fifo_rd_prefetch_if #(
  parameter int DSIZE = 32
);
  import fifo_rd_pkg::*;

  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic             m_valid;
  logic             m_ready;
  logic [DSIZE-1:0] m_data;

  modport master (
    input  rempty, rdata, m_ready,
    output rinc, m_valid, m_data
  );

  modport slave (
    output rempty, rdata, m_ready,
    input  rinc, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order output buffer (head/tail) with occupancy FSM.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   wr        write rdata this cycle (word arriving from the SRAM)
//   wdata     word to write
//   pop       head consumed this cycle
//   valid     buffer non-empty
//   head      oldest word
//   occ       current occupancy
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             pop,
  output logic             valid,
  output logic [DSIZE-1:0] head,
  output occ_e             occ
);

  occ_e             occ_q, occ_n;
  logic [DSIZE-1:0] head_q, head_n;
  logic [DSIZE-1:0] tail_q, tail_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= OCC_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q  <= occ_n;
      head_q <= head_n;
      tail_q <= tail_n;
    end
  end

  // The incoming word lands in the first slot that is free once any
  // simultaneous pop has shifted the tail forward.
  always_comb begin
    occ_n  = occ_q;
    head_n = head_q;
    tail_n = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (wr) begin
          head_n = wdata;
          occ_n  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({wr, pop})
          2'b10: begin
            tail_n = wdata;
            occ_n  = OCC_TWO;
          end
          2'b01: occ_n = OCC_EMPTY;
          2'b11: head_n = wdata;
          default: ;
        endcase
      end
      OCC_TWO: begin
        // A write without pop cannot occur here: rinc is withheld whenever
        // the buffer plus the in-flight word would exceed two entries.
        if (pop) begin
          head_n = tail_q;
          if (wr) tail_n = wdata;
          else    occ_n  = OCC_ONE;
        end
      end
      default: occ_n = OCC_EMPTY;
    endcase
  end

  assign valid = (occ_q != OCC_EMPTY);
  assign head  = head_q;
  assign occ   = occ_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// Read-side drain engine: pops the FIFO, absorbs the one-cycle SRAM read
// latency and presents the words as a full-throughput valid/ready stream.
// Ports:
//   rclk     read-domain clock
//   rrst     synchronous active-high reset
//   rd       FIFO read port + output stream (master modport)
//   pop_cnt  words delivered, wraps modulo 2^CSIZE
module fifo_rd_prefetch
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int CSIZE = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  fifo_rd_prefetch_if.master   rd,
  output logic [CSIZE-1:0]     pop_cnt
);

  occ_e       occ;
  logic       infl;
  logic       pop;
  logic [2:0] lvl;

  assign pop = rd.m_valid & rd.m_ready;

  // Committed words after this cycle: buffered + in flight - consumed.
  // pop implies occ >= 1, so this never underflows.
  assign lvl = 3'(occ) + {2'b00, infl} - {2'b00, pop};

  assign rd.rinc = !rrst && !rd.rempty && (lvl < 3'(BUF_DEPTH));

  always_ff @(posedge rclk) begin
    if (rrst) begin
      infl    <= 1'b0;
      pop_cnt <= '0;
    end else begin
      infl <= rd.rinc;
      if (pop) pop_cnt <= pop_cnt + 1'b1;
    end
  end

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .clk   (rclk),
    .rst   (rrst),
    .wr    (infl),
    .wdata (rd.rdata),
    .pop   (pop),
    .valid (rd.m_valid),
    .head  (rd.m_data),
    .occ   (occ)
  );

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
module tb_fifo_rd_prefetch;
  import fifo_rd_pkg::*;

  localparam int DSZ = 32;
  localparam int CSZ = 4;

  logic           rclk = 1'b0;
  logic           rrst;
  logic [CSZ-1:0] pop_cnt;

  fifo_rd_prefetch_if #(.DSIZE(DSZ)) rd_if ();

  fifo_rd_prefetch #(.DSIZE(DSZ), .CSIZE(CSZ)) dut (
    .rclk    (rclk),
    .rrst    (rrst),
    .rd      (rd_if),
    .pop_cnt (pop_cnt)
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  logic [DSZ-1:0] fifo_q[$];  // words still inside the FIFO
  logic [DSZ-1:0] exp_q[$];   // scoreboard: words not yet delivered

  bit rinc_s = 1'b0;
  bit rst_s  = 1'b1;
  bit infl_m = 1'b0;
  bit hold_s = 1'b0;
  logic [DSZ-1:0] data_s = '0;
  int cyc = 0;
  int exp_cnt = 0;
  int rinc_cnt, first_rinc, last_rinc;
  int dlv, first_dlv, last_dlv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rinc_cnt = 0; first_rinc = -1; last_rinc = -1;
    dlv = 0; first_dlv = -1; last_dlv = -1;
  endtask

  task automatic push(input logic [DSZ-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One read-clock cycle: inputs change 1ns after the rising edge, outputs
  // are sampled and scored on the falling edge.
  task automatic tick(input bit rdy, input bit rst);
    int outstanding, buffered;
    bit pop_m, exp_rinc;
    logic [DSZ-1:0] w;
    @(posedge rclk);
    #1;
    cyc++;
    if (rst_s) begin
      outstanding = exp_q.size() - fifo_q.size();
      repeat (outstanding) void'(exp_q.pop_front());
      exp_cnt = 0;
      infl_m  = 1'b0;
    end else begin
      infl_m = rinc_s;
    end
    if (rinc_s && !rst_s && fifo_q.size() > 0) rd_if.rdata = fifo_q.pop_front();
    else rd_if.rdata = 32'hBAD0_0000 | 32'(cyc);
    rrst          = rst;
    rd_if.m_ready = rdy;
    rd_if.rempty  = (fifo_q.size() == 0);
    @(negedge rclk);
    outstanding = exp_q.size() - fifo_q.size();
    buffered    = outstanding - int'(infl_m);
    pop_m       = (buffered > 0) && rdy;
    exp_rinc    = !rst && !rd_if.rempty && ((outstanding - int'(pop_m)) < 2);
    chk("rinc", rd_if.rinc, exp_rinc);
    chk("m_valid", rd_if.m_valid, buffered > 0);
    chk("pop_cnt", pop_cnt, exp_cnt % (1 << CSZ));
    if (hold_s) chk("hold_data", rd_if.m_data, data_s);
    if (rd_if.rinc) begin
      rinc_cnt++;
      if (first_rinc < 0) first_rinc = cyc;
      last_rinc = cyc;
    end
    if (!rst && rd_if.m_valid && rd_if.m_ready) begin
      if (exp_q.size() == 0) chk("extra_word", 1, 0);
      else begin
        w = exp_q.pop_front();
        chk("m_data", rd_if.m_data, w);
      end
      exp_cnt++;
      dlv++;
      if (first_dlv < 0) first_dlv = cyc;
      last_dlv = cyc;
    end
    hold_s = !rst && rd_if.m_valid && !rd_if.m_ready;
    data_s = rd_if.m_data;
    rinc_s = rd_if.rinc;
    rst_s  = rst;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    rrst = 1'b1;
    rd_if.m_ready = 1'b0;
    rd_if.rempty  = 1'b1;
    rd_if.rdata   = '0;
    clear_stats();

    // Reset values
    tick(0, 1);
    chk("rst_m_valid", rd_if.m_valid, 0);
    chk("rst_m_data", rd_if.m_data, 0);
    chk("rst_pop_cnt", pop_cnt, 0);

    // First word: rempty low for one cycle after reset release
    push(32'hA5A5_0001);
    tick(1, 1);
    chk("rst_rinc_nonempty", rd_if.rinc, 0);
    clear_stats();
    repeat (5) tick(1, 0);
    chk("first_rinc_cnt", rinc_cnt, 1);
    chk("first_latency", first_dlv - first_rinc, 2);
    chk("first_dlv", dlv, 1);
    chk("first_pop_cnt", pop_cnt, 1);

    // Streaming 1..8
    for (int i = 1; i <= 8; i++) push(32'(i));
    tick(1, 1);
    clear_stats();
    repeat (12) tick(1, 0);
    chk("stream_rinc_cnt", rinc_cnt, 8);
    chk("stream_rinc_span", last_rinc - first_rinc, 7);
    chk("stream_dlv", dlv, 8);
    chk("stream_dlv_span", last_dlv - first_dlv, 7);
    chk("stream_latency", first_dlv - first_rinc, 2);
    chk("stream_pop_cnt", pop_cnt, 8);

    // Backpressure
    for (int i = 1; i <= 6; i++) push(32'h100 + 32'(i));
    tick(0, 1);
    clear_stats();
    repeat (6) tick(0, 0);
    chk("bp_rinc_cnt", rinc_cnt, 2);
    chk("bp_occ", dut.occ, OCC_TWO);
    chk("bp_head", rd_if.m_data, 32'h101);
    chk("bp_dlv", dlv, 0);
    clear_stats();
    start = cyc + 1;
    repeat (8) tick(1, 0);
    chk("bp_resume_first", first_dlv, start);
    chk("bp_resume_dlv", dlv, 6);
    chk("bp_resume_span", last_dlv - first_dlv, 5);

    // Reset mid-flight
    push(32'hDEAD_0001);
    tick(1, 1);
    clear_stats();
    tick(1, 0);
    chk("mf_rinc", rd_if.rinc, 1);
    tick(1, 1);
    tick(1, 0);
    chk("mf_m_valid", rd_if.m_valid, 0);
    chk("mf_pop_cnt", pop_cnt, 0);
    repeat (3) tick(1, 0);
    chk("mf_dlv", dlv, 0);
    chk("mf_scoreboard", exp_q.size(), 0);

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) push(32'h200 + 32'(i));
    tick(1, 1);
    clear_stats();
    repeat (22) tick(1, 0);
    chk("wrap_dlv", dlv, 17);
    chk("wrap_pop_cnt", pop_cnt, 1);

    // Empty boundary: two buffered words, FIFO then empty, ready toggling
    push(32'h300);
    push(32'h301);
    tick(0, 1);
    clear_stats();
    repeat (4) tick(0, 0);
    chk("eb_rinc_cnt", rinc_cnt, 2);
    chk("eb_occ_two", dut.occ, OCC_TWO);
    chk("eb_rempty", rd_if.rempty, 1);
    for (int i = 0; i < 6; i++) tick(i % 2 == 0, 0);
    chk("eb_dlv", dlv, 2);
    chk("eb_rinc_total", rinc_cnt, 2);
    chk("eb_m_valid", rd_if.m_valid, 0);
    chk("eb_occ_empty", dut.occ, OCC_EMPTY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
